region_bus_fabric: RTL and testbench

- Parametrised successor of the single-cycle address-decoded interconnect between the core data port and the memory-mapped slaves (ROMs, RAM, PIO).
- Adds:
  - a request/acknowledge handshake on both the master and slave sides;
  - per-region fixed-latency or ack-driven slaves;
  - a registered response path;
  - decode-error and timeout reporting.
- Sits between core_top data memory signals and the slave array in top.

---
 rtl/fabric_pkg.sv | 14 +
 rtl/region_decoder.sv | 29 ++
 rtl/region_bus_fabric.sv | 176 +++++++++++++++++
 tb/tb_region_bus_fabric.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_pkg.sv
// Shared types and constants for the region bus fabric.
package fabric_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [31:0] ERR_DATA        = 32'hDEAD_BEEF;
  localparam int          DEFAULT_TIMEOUT = 16;

  // Width of a region index; a single region still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/region_decoder.sv
// Combinational priority decoder: hit when base <= addr < end, lowest region index wins.
module region_decoder
  import fabric_pkg::*;
#(
  parameter int REGIONS = 5,
  parameter int ADDR_W  = 32,
  parameter int SEL_W   = sel_width(REGIONS)
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [REGIONS*ADDR_W-1:0] region_base,
  input  logic [REGIONS*ADDR_W-1:0] region_end,
  output logic                      hit,
  output logic [SEL_W-1:0]          sel
);

  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < REGIONS; i++) begin
      if (!hit &&
          addr >= region_base[i*ADDR_W +: ADDR_W] &&
          addr <  region_end[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/region_bus_fabric.sv
// Request/acknowledge interconnect from the core data port to REGIONS memory-mapped slaves.
// Optional error log (err_addr, err_count) is built when FABRIC_ERRLOG_EN is defined.
module region_bus_fabric
  import fabric_pkg::*;
#(
  parameter int                 REGIONS        = 5,
  parameter int                 ADDR_W         = 32,
  parameter int                 DATA_W         = 32,
  parameter logic [REGIONS-1:0] FIXED_LAT_MASK = {REGIONS{1'b1}},
  parameter int                 TIMEOUT        = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_m,
  input  logic                      we_m,
  input  logic [ADDR_W-1:0]         addr_m,
  input  logic [DATA_W-1:0]         wd_m,
  output logic                      ready_m,
  output logic                      ack_m,
  output logic                      err_m,
  output logic [DATA_W-1:0]         rd_m,
  input  logic [REGIONS*ADDR_W-1:0] region_base,
  input  logic [REGIONS*ADDR_W-1:0] region_end,
  output logic [REGIONS-1:0]        req_s,
  output logic [REGIONS-1:0]        we_s,
  output logic [REGIONS*ADDR_W-1:0] addr_s,
  output logic [REGIONS*DATA_W-1:0] wd_s,
  input  logic [REGIONS*DATA_W-1:0] rd_s,
  input  logic [REGIONS-1:0]        ack_s
`ifdef FABRIC_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [15:0]               err_count
`endif
);

  localparam int SEL_W = sel_width(REGIONS);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [DATA_W-1:0] ERR_RD = DATA_W'(ERR_DATA);

  state_t             state;
  logic               we_q;
  logic               hit_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt;

  logic               dec_hit;
  logic [SEL_W-1:0]   dec_sel;
  logic [REGIONS-1:0] dec_onehot;
  logic [ADDR_W-1:0]  dec_offset;
  logic               sel_fixed;
  logic               sel_ack;
  logic [DATA_W-1:0]  sel_rd;

  region_decoder #(
    .REGIONS (REGIONS),
    .ADDR_W  (ADDR_W),
    .SEL_W   (SEL_W)
  ) u_decoder (
    .addr        (addr_m),
    .region_base (region_base),
    .region_end  (region_end),
    .hit         (dec_hit),
    .sel         (dec_sel)
  );

  assign dec_onehot = REGIONS'(1'b1) << dec_sel;
  assign dec_offset = addr_m - region_base[dec_sel*ADDR_W +: ADDR_W];
  assign sel_fixed  = FIXED_LAT_MASK[sel_q];
  assign sel_ack    = ack_s[sel_q];
  assign sel_rd     = rd_s[sel_q*DATA_W +: DATA_W];

  // Decode happens at acceptance so req_s can be registered; a miss still
  // passes through REQ (without req_s) so that its ack lands two cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ready_m <= 1'b1;
      ack_m   <= 1'b0;
      err_m   <= 1'b0;
      rd_m    <= '0;
      req_s   <= '0;
      we_s    <= '0;
      addr_s  <= '0;
      wd_s    <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      sel_q   <= '0;
      cnt     <= '0;
    end else begin
      req_s <= '0;
      ack_m <= 1'b0;
      case (state)
        IDLE: begin
          if (req_m) begin
            ready_m <= 1'b0;
            we_q    <= we_m;
            hit_q   <= dec_hit;
            sel_q   <= dec_sel;
            if (dec_hit) begin
              req_s  <= dec_onehot;
              we_s   <= we_m ? dec_onehot : '0;
              addr_s <= {REGIONS{dec_offset}};
              wd_s   <= {REGIONS{wd_m}};
            end
            state <= REQ;
          end
        end
        REQ: begin
          cnt <= '0;
          if (hit_q) begin
            state <= WAIT;
          end else begin
            ack_m <= 1'b1;
            err_m <= 1'b1;
            rd_m  <= ERR_RD;
            state <= RESP;
          end
        end
        WAIT: begin
          // Ack is checked before the timeout so a last-cycle ack still succeeds.
          if (sel_fixed || sel_ack) begin
            ack_m  <= 1'b1;
            err_m  <= 1'b0;
            rd_m   <= we_q ? '0 : sel_rd;
            we_s   <= '0;
            addr_s <= '0;
            wd_s   <= '0;
            state  <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            ack_m  <= 1'b1;
            err_m  <= 1'b1;
            rd_m   <= ERR_RD;
            we_s   <= '0;
            addr_s <= '0;
            wd_s   <= '0;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          err_m   <= 1'b0;
          rd_m    <= '0;
          ready_m <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FABRIC_ERRLOG_EN
  logic [ADDR_W-1:0] log_addr;

  // Logged one cycle after the erroring ack_m, using the address latched at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      log_addr  <= '0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      if (state == IDLE && req_m) begin
        log_addr <= addr_m;
      end
      if (ack_m && err_m) begin
        err_addr <= log_addr;
        if (err_count != 16'hFFFF) begin
          err_count <= err_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_region_bus_fabric.sv
// Directed bench for region_bus_fabric: a transaction-timeline model checked every cycle plus literal pins.
module tb_region_bus_fabric;

  localparam int REGIONS = 5;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      req_m, we_m;
  logic [ADDR_W-1:0]         addr_m;
  logic [DATA_W-1:0]         wd_m;
  logic                      ready_m, ack_m, err_m;
  logic [DATA_W-1:0]         rd_m;
  logic [REGIONS*ADDR_W-1:0] region_base, region_end;
  logic [REGIONS-1:0]        req_s, we_s, ack_s;
  logic [REGIONS*ADDR_W-1:0] addr_s;
  logic [REGIONS*DATA_W-1:0] wd_s, rd_s;

  region_bus_fabric #(
    .REGIONS        (REGIONS),
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .FIXED_LAT_MASK (5'b11011),
    .TIMEOUT        (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_m       (req_m),
    .we_m        (we_m),
    .addr_m      (addr_m),
    .wd_m        (wd_m),
    .ready_m     (ready_m),
    .ack_m       (ack_m),
    .err_m       (err_m),
    .rd_m        (rd_m),
    .region_base (region_base),
    .region_end  (region_end),
    .req_s       (req_s),
    .we_s        (we_s),
    .addr_s      (addr_s),
    .wd_s        (wd_s),
    .rd_s        (rd_s),
    .ack_s       (ack_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] base_tab [REGIONS];
  logic [31:0] end_tab  [REGIONS];
  logic [4:0]  fixed_mask = 5'b11011;

  // Planned transaction: the whole expected timeline follows from these.
  logic        p_valid = 1'b0;
  logic        p_hit, p_we, p_err;
  int          p_ta, p_tack, p_sel;
  logic [31:0] p_off, p_wd, p_rd;

  int          last_ack_cyc, last_req_cyc;
  logic [31:0] last_rd;
  logic        last_err;
  logic [4:0]  last_req_s, last_we_s;
  logic [159:0] last_addr_s, last_wd_s;

  task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_decode(input logic [31:0] a, output logic h, output int s);
    h = 1'b0;
    s = 0;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (a >= base_tab[i] && a < end_tab[i]) begin
        h = 1'b1;
        s = i;
      end
    end
  endfunction

  // Snapshots of interesting DUT events for the literal checks.
  always @(negedge clk) begin
    if (ack_m === 1'b1) begin
      last_ack_cyc = cyc;
      last_rd      = rd_m;
      last_err     = err_m;
    end
    if (req_s !== 5'b0) begin
      last_req_cyc = cyc;
      last_req_s   = req_s;
      last_we_s    = we_s;
      last_addr_s  = addr_s;
      last_wd_s    = wd_s;
    end
  end

  // Per-cycle comparison of every output against the planned timeline.
  always @(negedge clk) begin
    logic        e_ready, e_ack, e_err;
    logic [4:0]  e_req, e_we;
    logic [159:0] e_addr, e_wd;
    logic [31:0] e_rd;
    int          c;
    c = cyc;
    e_ready = 1'b1; e_ack = 1'b0; e_err = 1'b0; e_rd = '0;
    e_req = '0; e_we = '0; e_addr = '0; e_wd = '0;
    if (p_valid && c >= p_ta) begin
      e_ready = !(c > p_ta && c <= p_tack);
      if (p_hit && c == p_ta + 1) e_req = 5'b00001 << p_sel;
      if (p_hit && c > p_ta && c < p_tack) begin
        if (p_we) e_we = 5'b00001 << p_sel;
        e_addr = {5{p_off}};
        e_wd   = {5{p_wd}};
      end
      if (c == p_tack) begin
        e_ack = 1'b1;
        e_err = p_err;
        e_rd  = p_rd;
      end
    end
    check_output("cyc_ready_m", ready_m, e_ready);
    check_output("cyc_req_s", req_s, e_req);
    check_output("cyc_we_s", we_s, e_we);
    check_output("cyc_addr_s", addr_s, e_addr);
    check_output("cyc_wd_s", wd_s, e_wd);
    check_output("cyc_ack_m", ack_m, e_ack);
    check_output("cyc_err_m", err_m, e_err);
    check_output("cyc_rd_m", rd_m, e_rd);
  end

  // Runs one transaction starting now; ack_delay is cycles from req_s to ack_s (-1 = never),
  // abort_at > 0 asserts reset mid-cycle that many cycles after acceptance.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] lane_val, input int ack_delay, input int abort_at,
                                output int ta);
    logic h;
    int   s;
    int   t_cap;
    for (int k = 0; k < 40 && ready_m !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    check_output("ready_before_req", ready_m, 1'b1);
    ta = cyc;
    model_decode(addr, h, s);
    t_cap  = -1;
    p_ta   = ta;
    p_hit  = h;
    p_sel  = s;
    p_we   = we;
    p_wd   = wd;
    p_off  = addr - base_tab[s];
    if (!h) begin
      p_tack = ta + 2; p_err = 1'b1; p_rd = 32'hDEAD_BEEF;
    end else if (fixed_mask[s]) begin
      p_tack = ta + 3; p_err = 1'b0; p_rd = we ? 32'h0 : lane_val; t_cap = ta + 2;
    end else if (ack_delay >= 1 && ack_delay <= TIMEOUT) begin
      p_tack = ta + 2 + ack_delay; p_err = 1'b0; p_rd = we ? 32'h0 : lane_val; t_cap = ta + 1 + ack_delay;
    end else begin
      p_tack = ta + 2 + TIMEOUT; p_err = 1'b1; p_rd = 32'hDEAD_BEEF;
    end
    p_valid      = 1'b1;
    last_ack_cyc = -1;
    last_req_cyc = -1;
    req_m  = 1'b1;
    we_m   = we;
    addr_m = addr;
    wd_m   = wd;
    ack_s  = '0;
    rd_s   = {5{{16'hBAD0, cyc[15:0]}}};
    do begin
      @(posedge clk); #1;
      req_m  = 1'b0;
      we_m   = !we;
      addr_m = 32'h5A5A_5A5A;
      wd_m   = {16'hC3C3, cyc[15:0]};
      rd_s   = {5{{16'hBAD0, cyc[15:0]}}};
      if (h && cyc == t_cap) rd_s[s*32 +: 32] = lane_val;
      ack_s = '0;
      if (h && !fixed_mask[s]) begin
        if (ack_delay >= 0 && cyc == ta + 1 + ack_delay) ack_s[s] = 1'b1;
        if (cyc == ta + 3) ack_s[0] = 1'b1;
      end
      if (abort_at > 0 && cyc == ta + abort_at) begin
        #2;
        reset   = 1'b1;
        p_valid = 1'b0;
        #1;
        check_output("abort_ready_m", ready_m, 1'b1);
        check_output("abort_req_s", req_s, 5'b0);
        check_output("abort_addr_s", addr_s, 160'b0);
        check_output("abort_ack_m", ack_m, 1'b0);
        check_output("abort_rd_m", rd_m, 32'h0);
        ack_s = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        repeat (4) begin
          @(posedge clk); #1;
        end
        check_output("abort_no_ack", last_ack_cyc == -1, 1'b1);
        return;
      end
    end while (cyc < p_tack + 1);
    ack_s = '0;
  endtask

  initial begin
    int ta, tb;
    base_tab = '{32'h0000_0000, 32'h0000_1000, 32'h0000_3000, 32'h0000_2000, 32'h0000_0800};
    end_tab  = '{32'h0000_1000, 32'h0000_2000, 32'h0000_4000, 32'h0000_2100, 32'h0000_8000};
    for (int i = 0; i < REGIONS; i++) begin
      region_base[i*32 +: 32] = base_tab[i];
      region_end[i*32 +: 32]  = end_tab[i];
    end
    reset = 1'b1; req_m = 1'b0; we_m = 1'b0; addr_m = '0; wd_m = '0; rd_s = '0; ack_s = '0;
    #2;
    check_output("rst_ready_m", ready_m, 1'b1);
    check_output("rst_ack_m", ack_m, 1'b0);
    check_output("rst_req_s", req_s, 5'b0);
    check_output("rst_rd_m", rd_m, 32'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // Fixed-latency read from region 1.
    apply_stimulus(1'b0, 32'h0000_1004, 32'h0, 32'h0000_1234, -1, 0, ta);
    check_output("t1_addr_s", last_addr_s[63:32], 32'h4);
    check_output("t1_req_s", last_req_s, 5'b00010);
    check_output("t1_latency", last_ack_cyc - ta, 3);
    check_output("t1_rd_m", last_rd, 32'h1234);
    check_output("t1_err_m", last_err, 1'b0);

    // Back-to-back write to the PIO region.
    apply_stimulus(1'b1, 32'h0000_2008, 32'h0000_00A5, 32'h0, -1, 0, tb);
    check_output("t2_b2b_accept", tb - ta, 4);
    check_output("t2_req_s", last_req_s, 5'b01000);
    check_output("t2_we_s", last_we_s, 5'b01000);
    check_output("t2_wd_lane3", last_wd_s[127:96], 32'hA5);
    check_output("t2_latency", last_ack_cyc - tb, 3);
    check_output("t2_rd_m", last_rd, 32'h0);

    // Unmapped address.
    apply_stimulus(1'b0, 32'h0009_0000, 32'h0, 32'h0, -1, 0, ta);
    check_output("t3_no_req_s", last_req_cyc == -1, 1'b1);
    check_output("t3_latency", last_ack_cyc - ta, 2);
    check_output("t3_err_m", last_err, 1'b1);
    check_output("t3_rd_m", last_rd, 32'hDEAD_BEEF);

    // Ack-driven region, ack 5 cycles after req_s; ack_s[0] noise in WAIT.
    apply_stimulus(1'b0, 32'h0000_3010, 32'h0, 32'h0000_0077, 5, 0, ta);
    check_output("t4_addr_s", last_addr_s[95:64], 32'h10);
    check_output("t4_latency", last_ack_cyc - ta, 7);
    check_output("t4_rd_m", last_rd, 32'h77);
    check_output("t4_err_m", last_err, 1'b0);

    // Never acks: timeout after 16 WAIT cycles.
    apply_stimulus(1'b0, 32'h0000_3000, 32'h0, 32'h0, -1, 0, ta);
    check_output("t5_latency", last_ack_cyc - ta, 18);
    check_output("t5_err_m", last_err, 1'b1);
    check_output("t5_rd_m", last_rd, 32'hDEAD_BEEF);
    check_output("t5_ready_next", ready_m, 1'b1);

    // Ack on the final WAIT cycle beats the timeout.
    apply_stimulus(1'b0, 32'h0000_3FFC, 32'h0, 32'h0000_600D, 16, 0, ta);
    check_output("t6_latency", last_ack_cyc - ta, 18);
    check_output("t6_err_m", last_err, 1'b0);
    check_output("t6_rd_m", last_rd, 32'h600D);

    // Ack in the req_s cycle is ignored, so it times out.
    apply_stimulus(1'b0, 32'h0000_3004, 32'h0, 32'h0000_1111, 0, 0, ta);
    check_output("t7_err_m", last_err, 1'b1);
    check_output("t7_latency", last_ack_cyc - ta, 18);

    // Region boundaries and overlap priority.
    apply_stimulus(1'b0, 32'h0000_2000, 32'h0, 32'h0000_2222, -1, 0, ta);
    check_output("t8_req_s", last_req_s, 5'b01000);
    check_output("t8_addr_s", last_addr_s[127:96], 32'h0);
    apply_stimulus(1'b0, 32'h0000_0800, 32'h0, 32'h0000_55AA, -1, 0, ta);
    check_output("t9_req_s", last_req_s, 5'b00001);
    check_output("t9_addr_s", last_addr_s[31:0], 32'h800);
    check_output("t9_rd_m", last_rd, 32'h55AA);
    apply_stimulus(1'b0, 32'h0000_0FFF, 32'h0, 32'h0000_0F0F, -1, 0, ta);
    apply_stimulus(1'b0, 32'h0000_1000, 32'h0, 32'h0000_1010, -1, 0, ta);
    check_output("t10_req_s", last_req_s, 5'b00010);
    apply_stimulus(1'b1, 32'h0000_5000, 32'hCAFE_F00D, 32'h0, -1, 0, ta);
    check_output("t10_r4_req_s", last_req_s, 5'b10000);
    check_output("t10_r4_addr_s", last_addr_s[159:128], 32'h4800);
    apply_stimulus(1'b0, 32'h0000_7FFF, 32'h0, 32'h0000_7777, -1, 0, ta);
    apply_stimulus(1'b0, 32'h0000_8000, 32'h0, 32'h0, -1, 0, ta);
    check_output("t10_end_miss", last_err, 1'b1);

    // Write to the ack region.
    apply_stimulus(1'b1, 32'h0000_3020, 32'h1357_9BDF, 32'hFFFF_FFFF, 2, 0, ta);
    check_output("t11_latency", last_ack_cyc - ta, 4);
    check_output("t11_rd_m", last_rd, 32'h0);

    // Reset during WAIT aborts with no ack, then a normal read recovers.
    apply_stimulus(1'b0, 32'h0000_3040, 32'h0, 32'h0, -1, 4, ta);
    apply_stimulus(1'b0, 32'h0000_4004, 32'h0, 32'h0000_ABCD, -1, 0, ta);
    check_output("t13_rd_m", last_rd, 32'hABCD);
    check_output("t13_latency", last_ack_cyc - ta, 3);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
